mc10_ram_arbiter: RTL and testbench
===================================

Name: mc10_ram_arbiter

Overview:
- Shares one single-port synchronous video/system RAM among three requesters: the MC6803 CPU bus, the VDG video fetch unit, and the HPS cassette/ROM loader.
- Sits between the CPU core bus (ADDRESS/rw/E_CLK/DATA) and the RAM macro.
- Stalls the CPU through its hold input when the CPU loses arbitration or is waiting for read data.
- Guarantees CPU forward progress with a starvation counter.

Parameters:
- ADDR_W, 14, RAM address width (16 KB).
- RAM_BASE, 16'h4000, first CPU address mapped to RAM.
- MAX_STALL, 4, consecutive denied CPU cycles before the CPU is forced to win.

Ports:
- Clk  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- cpu_vma  in  1  CPU valid memory access (E_CLK)
- cpu_rw  in  1  1=read, 0=write
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data to CPU
- cpu_hold  out  1  stall CPU core
- vid_req  in  1  video read request (level, held until ack)
- vid_addr  in  ADDR_W  video address
- vid_ack  out  1  one-cycle pulse, request accepted
- vid_rdata  out  8  video read data
- vid_valid  out  1  vid_rdata valid, exactly 1 cycle after vid_ack
- ldr_req  in  1  loader write request (level, held until ack)
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  8  loader data
- ldr_ack  out  1  one-cycle pulse, write performed
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data, registered, 1-cycle latency

Behaviour:
- cpu_in_win = cpu_vma and RAM_BASE <= cpu_addr < RAM_BASE + 2^ADDR_W. CPU accesses outside the window are ignored; cpu_hold=0 for them.
- Arbitration is one grant per cycle, combinational on current requests.
- Priority order: ldr > vid > cpu, except when force_cpu=1, which makes the order cpu > ldr > vid.
- Grant drives mem_addr/mem_we/mem_wdata the same cycle:
  - CPU uses cpu_addr minus RAM_BASE, truncated to ADDR_W.
  - Loader grant sets mem_we=1.
  - With no grant, mem_we=0 and mem_addr holds its last value.
- Owner register rd_owner in {NONE, CPU, VID} records who issued a read last cycle.
  - rd_owner=VID: vid_rdata<=mem_rdata passthrough, vid_valid=1.
  - rd_owner=CPU: cpu_rdata=mem_rdata.
- CPU state machine:
  - C_IDLE: cpu_in_win and not granted → cpu_hold=1, stay.
  - C_IDLE: granted write → cpu_hold=0, write done this cycle, stay C_IDLE.
  - C_IDLE: granted read → cpu_hold=1, go to C_DATA.
  - C_DATA: cpu_hold=0, cpu_rdata valid, return to C_IDLE. No new CPU grant is issued in C_DATA; other requesters may be granted.
- Starvation counter stall_cnt (3 bits min):
  - Increments each cycle cpu_in_win is denied in C_IDLE.
  - Clears on a CPU grant or when the CPU is not requesting.
  - force_cpu = (stall_cnt >= MAX_STALL).
  - Saturates; no wrap.
- vid_ack/ldr_ack pulse in the grant cycle. A requester holding req high after ack is treated as a new request next cycle.
- Simultaneous vid_req and ldr_req, no force: ldr granted, vid waits. Video starvation is acceptable (loader is only active with the CPU in reset).
- Reset:
  - Outputs: cpu_hold=0, vid_ack=0, vid_valid=0, ldr_ack=0, mem_we=0, mem_addr=0, cpu_rdata=0, vid_rdata=0.
  - State: rd_owner=NONE, CPU FSM=C_IDLE, stall_cnt=0.
  - RST asserted mid-read drops the pending read: no vid_valid, no CPU data phase.
- cpu_addr/cpu_rw must be stable while cpu_hold=1 (CPU core guarantee). The arbiter does not latch them.

Test Plan:
- Reset: RST=1 for 2 cycles with all requests high → all acks/valid/hold/mem_we = 0. First cycle after release: ldr granted.
- CPU read alone: cpu_addr=16'h4123, rw=1, RAM[0x0123]=8'hA5 → cycle N: mem_addr=0x0123, cpu_hold=1. Cycle N+1: cpu_hold=0, cpu_rdata=8'hA5.
- CPU write alone: cpu_addr=16'h7FFF, wdata=8'h3C → same cycle mem_we=1, mem_addr=0x3FFF, cpu_hold=0. A following read of 0x7FFF returns 8'h3C.
- Out-of-window: cpu_addr=16'h00C0 → cpu_hold=0, mem_we=0, no grant.
- Contention: vid_req held continuously with CPU read pending, MAX_STALL=4 → cpu_hold high for 4 denied cycles. 5th cycle CPU granted, vid_ack=0. Next cycle CPU gets data and vid_ack resumes.
- Loader vs video: ldr_req and vid_req together, ldr_addr=0x0010, ldr_wdata=8'h55 → ldr_ack first with mem_we=1. Next cycle vid_ack. vid_valid exactly one cycle after vid_ack with data from vid_addr.

Source files
------------

// File: rtl/mc10_ram_arbiter.sv
// mc10_ram_arbiter: shares one single-port synchronous RAM between the
// MC6803 CPU bus, the VDG video fetch unit and the HPS loader. One grant per
// cycle. Priority is loader > video > CPU, but a starved CPU is forced to the
// front. Read data returns one cycle after the grant and is steered by rd_owner.
module mc10_ram_arbiter #(
    parameter int          ADDR_W    = 14,
    parameter logic [15:0] RAM_BASE  = 16'h4000,
    parameter int          MAX_STALL = 4
) (
    input  logic              Clk,
    input  logic              RST,
    input  logic              cpu_vma,
    input  logic              cpu_rw,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_hold,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [7:0]        vid_rdata,
    output logic              vid_valid,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_wdata,
    output logic              ldr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    // The counter must be able to reach MAX_STALL; never narrower than 3 bits.
    localparam int CNT_W = ($clog2(MAX_STALL + 1) > 3) ? $clog2(MAX_STALL + 1) : 3;
    localparam logic [16:0]       RAM_END = {1'b0, RAM_BASE} + (17'd1 << ADDR_W);
    localparam logic [ADDR_W-1:0] BASE_LO = RAM_BASE[ADDR_W-1:0];

    typedef enum logic {C_IDLE, C_DATA} cpu_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID} owner_t;

    cpu_state_t        cpu_state;
    owner_t            rd_owner;
    logic [CNT_W-1:0]  stall_cnt;
    logic [ADDR_W-1:0] mem_addr_p1;
    logic [7:0]        cpu_rdata_p1;
    logic [7:0]        vid_rdata_p1;

    logic              cpu_in_win;
    logic              cpu_req;
    logic              force_cpu;
    logic              gnt_cpu;
    logic              gnt_ldr;
    logic              gnt_vid;
    logic [ADDR_W-1:0] cpu_mem_addr;

    // Subtracting only the low base bits gives the same truncated offset as a
    // full 16-bit subtraction, without leaving unused upper bits around.
    assign cpu_in_win   = cpu_vma && ({1'b0, cpu_addr} >= {1'b0, RAM_BASE}) &&
                          ({1'b0, cpu_addr} < RAM_END);
    assign cpu_mem_addr = cpu_addr[ADDR_W-1:0] - BASE_LO;
    assign cpu_req      = (cpu_state == C_IDLE) && cpu_in_win;
    assign force_cpu    = (stall_cnt >= CNT_W'(MAX_STALL));

    // One grant per cycle; nothing is granted while reset is held.
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_ldr = 1'b0;
        gnt_vid = 1'b0;
        if (!RST) begin
            if (force_cpu && cpu_req)
                gnt_cpu = 1'b1;
            else if (ldr_req)
                gnt_ldr = 1'b1;
            else if (vid_req)
                gnt_vid = 1'b1;
            else if (cpu_req)
                gnt_cpu = 1'b1;
        end
    end

    // Drive the RAM port from the winner; an idle cycle keeps the last address.
    always_comb begin
        mem_addr  = mem_addr_p1;
        mem_wdata = cpu_wdata;
        if (RST)
            mem_addr = '0;
        else if (gnt_ldr) begin
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end else if (gnt_vid)
            mem_addr = vid_addr;
        else if (gnt_cpu)
            mem_addr = cpu_mem_addr;
    end

    assign mem_we  = gnt_ldr || (gnt_cpu && !cpu_rw);
    assign ldr_ack = gnt_ldr;
    assign vid_ack = gnt_vid;

    // A granted CPU write completes at once; a granted read still waits a cycle.
    assign cpu_hold  = !RST && cpu_req && !(gnt_cpu && !cpu_rw);

    // Read data follows the requester that issued the read one cycle earlier.
    assign vid_valid = !RST && (rd_owner == OWN_VID);
    assign vid_rdata = RST ? 8'h00 : (vid_valid ? mem_rdata : vid_rdata_p1);
    assign cpu_rdata = RST ? 8'h00 :
                       ((rd_owner == OWN_CPU) ? mem_rdata : cpu_rdata_p1);

    // CPU FSM, read ownership, starvation counter and held output values.
    always_ff @(posedge Clk) begin
        if (RST) begin
            cpu_state    <= C_IDLE;
            rd_owner     <= OWN_NONE;
            stall_cnt    <= '0;
            mem_addr_p1  <= '0;
            cpu_rdata_p1 <= 8'h00;
            vid_rdata_p1 <= 8'h00;
        end else begin
            case (cpu_state)
                C_IDLE:  if (gnt_cpu && cpu_rw) cpu_state <= C_DATA;
                default: cpu_state <= C_IDLE;
            endcase

            if (gnt_vid)
                rd_owner <= OWN_VID;
            else if (gnt_cpu && cpu_rw)
                rd_owner <= OWN_CPU;
            else
                rd_owner <= OWN_NONE;

            if (gnt_cpu || !cpu_in_win)
                stall_cnt <= '0;
            else if (cpu_req && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;

            if (gnt_cpu || gnt_ldr || gnt_vid)
                mem_addr_p1 <= mem_addr;
            if (rd_owner == OWN_CPU)
                cpu_rdata_p1 <= mem_rdata;
            if (rd_owner == OWN_VID)
                vid_rdata_p1 <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mc10_ram_arbiter.sv
// Directed bench for mc10_ram_arbiter with a behavioural 16 KB registered RAM.
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
module tb_mc10_ram_arbiter;

    localparam int ADDR_W = 14;

    logic              Clk = 1'b0;
    logic              RST;
    logic              cpu_vma, cpu_rw;
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_wdata, cpu_rdata;
    logic              cpu_hold;
    logic              vid_req, vid_ack, vid_valid;
    logic [ADDR_W-1:0] vid_addr;
    logic [7:0]        vid_rdata;
    logic              ldr_req, ldr_ack;
    logic [ADDR_W-1:0] ldr_addr;
    logic [7:0]        ldr_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata, mem_rdata;

    logic [7:0] ram [0:(1<<ADDR_W)-1];
    int checks   = 0;
    int failures = 0;

    mc10_ram_arbiter #(.ADDR_W(ADDR_W), .RAM_BASE(16'h4000), .MAX_STALL(4)) dut (
        .Clk(Clk), .RST(RST),
        .cpu_vma(cpu_vma), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rdata(vid_rdata), .vid_valid(vid_valid),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 Clk = ~Clk;

    // Single-port RAM, read data registered with one cycle of latency.
    always @(posedge Clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
        ram[14'h0123] = 8'hA5;
        ram[14'h0200] = 8'h77;

        // Reset with every requester active
        RST = 1'b1; cpu_vma = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h4123;
        cpu_wdata = 8'h00; vid_req = 1'b1; vid_addr = 14'h0200;
        ldr_req = 1'b1; ldr_addr = 14'h0010; ldr_wdata = 8'h55;
        #2;
        check("rst0_ldr_ack", 16'(ldr_ack), 16'h0);
        check("rst0_vid_ack", 16'(vid_ack), 16'h0);
        check("rst0_hold", 16'(cpu_hold), 16'h0);
        check("rst0_we", 16'(mem_we), 16'h0);
        check("rst0_vvalid", 16'(vid_valid), 16'h0);
        cyc(); #2;
        check("rst1_ldr_ack", 16'(ldr_ack), 16'h0);
        check("rst1_vid_ack", 16'(vid_ack), 16'h0);
        check("rst1_hold", 16'(cpu_hold), 16'h0);
        check("rst1_mem_addr", 16'(mem_addr), 16'h0);
        check("rst1_cpu_rdata", 16'(cpu_rdata), 16'h0);
        check("rst1_vid_rdata", 16'(vid_rdata), 16'h0);

        // First cycle out of reset: loader wins, video and CPU wait
        cyc(); RST = 1'b0; #2;
        check("lv_ldr_ack", 16'(ldr_ack), 16'h1);
        check("lv_we", 16'(mem_we), 16'h1);
        check("lv_addr", 16'(mem_addr), 16'h0010);
        check("lv_wdata", 16'(mem_wdata), 16'h55);
        check("lv_vid_ack0", 16'(vid_ack), 16'h0);
        check("lv_hold", 16'(cpu_hold), 16'h1);
        cyc(); ldr_req = 1'b0; cpu_vma = 1'b0; #2;
        check("lv_vid_ack", 16'(vid_ack), 16'h1);
        check("lv_vid_addr", 16'(mem_addr), 16'h0200);
        check("lv_vid_we", 16'(mem_we), 16'h0);
        check("lv_hold_off", 16'(cpu_hold), 16'h0);
        cyc(); vid_req = 1'b0; #2;
        check("lv_vvalid", 16'(vid_valid), 16'h1);
        check("lv_vrdata", 16'(vid_rdata), 16'h77);
        check("lv_vid_ack_end", 16'(vid_ack), 16'h0);
        cyc(); #2;
        check("lv_vvalid_end", 16'(vid_valid), 16'h0);

        // CPU read alone
        cyc(); cpu_vma = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h4123; #2;
        check("rd_addr", 16'(mem_addr), 16'h0123);
        check("rd_hold", 16'(cpu_hold), 16'h1);
        check("rd_we", 16'(mem_we), 16'h0);
        cyc(); #2;
        check("rd_hold_data", 16'(cpu_hold), 16'h0);
        check("rd_data", 16'(cpu_rdata), 16'hA5);
        cyc(); cpu_vma = 1'b0; #2;
        check("rd_idle_hold", 16'(cpu_hold), 16'h0);

        // CPU write at the top of the window, then read it back
        cyc(); cpu_vma = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h7FFF; cpu_wdata = 8'h3C; #2;
        check("wr_we", 16'(mem_we), 16'h1);
        check("wr_addr", 16'(mem_addr), 16'h3FFF);
        check("wr_wdata", 16'(mem_wdata), 16'h3C);
        check("wr_hold", 16'(cpu_hold), 16'h0);
        cyc(); cpu_rw = 1'b1; #2;
        check("wrb_hold", 16'(cpu_hold), 16'h1);
        check("wrb_we", 16'(mem_we), 16'h0);
        cyc(); #2;
        check("wrb_data", 16'(cpu_rdata), 16'h3C);
        check("wrb_hold_rel", 16'(cpu_hold), 16'h0);

        // Outside the window: ignored, mem_addr keeps the last grant
        cyc(); cpu_addr = 16'h00C0; #2;
        check("oow_hold", 16'(cpu_hold), 16'h0);
        check("oow_we", 16'(mem_we), 16'h0);
        check("oow_addr_held", 16'(mem_addr), 16'h3FFF);
        cyc(); cpu_addr = 16'h8000; #2;
        check("oow_hi_hold", 16'(cpu_hold), 16'h0);
        cyc(); cpu_addr = 16'h3FFF; #2;
        check("oow_lo_hold", 16'(cpu_hold), 16'h0);

        // Contention: video holds its request while the CPU reads 0x4010
        cyc(); cpu_addr = 16'h4010; vid_req = 1'b1; vid_addr = 14'h0200;
        for (int i = 1; i <= 4; i++) begin
            #2;
            check($sformatf("ct%0d_vid_ack", i), 16'(vid_ack), 16'h1);
            check($sformatf("ct%0d_hold", i), 16'(cpu_hold), 16'h1);
            if (i > 1) check($sformatf("ct%0d_vvalid", i), 16'(vid_valid), 16'h1);
            cyc();
        end
        #2;
        check("ct5_vid_ack", 16'(vid_ack), 16'h0);
        check("ct5_hold", 16'(cpu_hold), 16'h1);
        check("ct5_addr", 16'(mem_addr), 16'h0010);
        check("ct5_vvalid", 16'(vid_valid), 16'h1);
        cyc(); #2;
        check("ct6_hold", 16'(cpu_hold), 16'h0);
        check("ct6_cpu_data", 16'(cpu_rdata), 16'h55);
        check("ct6_vid_ack", 16'(vid_ack), 16'h1);
        check("ct6_vvalid", 16'(vid_valid), 16'h0);
        cyc(); cpu_vma = 1'b0; #2;
        check("ct7_vvalid", 16'(vid_valid), 16'h1);
        check("ct7_vrdata", 16'(vid_rdata), 16'h77);

        // Reset in the middle of a video read drops the data phase
        cyc(); RST = 1'b1; vid_req = 1'b0; #2;
        check("mr_vvalid_rst", 16'(vid_valid), 16'h0);
        check("mr_cpu_rdata", 16'(cpu_rdata), 16'h0);
        cyc(); RST = 1'b0; #2;
        check("mr_vvalid_after", 16'(vid_valid), 16'h0);
        check("mr_hold_after", 16'(cpu_hold), 16'h0);

        // Reset in the middle of a CPU read drops the CPU data phase
        cyc(); cpu_vma = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h4123; #2;
        check("mc_hold", 16'(cpu_hold), 16'h1);
        cyc(); RST = 1'b1; cpu_vma = 1'b0; #2;
        check("mc_hold_rst", 16'(cpu_hold), 16'h0);
        cyc(); RST = 1'b0; #2;
        check("mc_rdata_after", 16'(cpu_rdata), 16'h0);
        check("mc_hold_after", 16'(cpu_hold), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
